// File: rtl/stage_sequencer.sv
// Multi-cycle fetch/decode/execute/memory/writeback sequencer for the RISC-V datapath.
// Build option STAGE_SEQUENCER_PERF_CNT_EN adds retired-instruction and active-cycle counters.
//
// state  | meaning
// IDLE   | halted, waiting for run
// FETCH  | instruction request pending, latch IR on imem_ready
// DECODE | control_unit decode settles
// EXEC   | ALU result / branch resolve, ends non-memory non-writeback instructions
// MEM    | data request pending until dmem_ready
// WB     | register file write and PC update
// TRAP   | memory wait timeout, held until reset
module stage_sequencer #(
    parameter int MEM_TIMEOUT = 15,
    parameter int TMR_W       = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        run,
    input  logic        reg_write,
    input  logic        mem_to_reg,
    input  logic        mem_write,
    input  logic        b_beq,
    input  logic        b_jal,
    input  logic        b_jalr,
    input  logic        alu_zero,
    output logic        imem_req,
    input  logic        imem_ready,
    output logic        dmem_req,
    output logic        dmem_we,
    input  logic        dmem_ready,
    output logic        ir_we,
    output logic        rf_we,
    output logic        pc_we,
    output logic [1:0]  pc_sel,
    output logic        instr_done,
    output logic [2:0]  state,
    output logic        fault,
    output logic [31:0] retired_cnt,
    output logic [31:0] cycle_cnt
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_MEM    = 3'd4,
        S_WB     = 3'd5,
        S_TRAP   = 3'd6
    } state_t;

    state_t           state_q, state_d;
    logic [TMR_W-1:0] wait_q, wait_d;
    logic             fault_q;
    logic             timeout;
    state_t           end_state;

    assign timeout   = (MEM_TIMEOUT != 0) && (wait_q == TMR_W'(MEM_TIMEOUT));
    assign end_state = run ? S_FETCH : S_IDLE;

    always_comb begin
        state_d  = state_q;
        wait_d   = wait_q;
        imem_req = 1'b0;
        dmem_req = 1'b0;
        dmem_we  = 1'b0;
        ir_we    = 1'b0;
        rf_we    = 1'b0;
        pc_we    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (run) state_d = S_FETCH;
            end
            S_FETCH: begin
                imem_req = 1'b1;
                if (imem_ready) begin
                    ir_we   = 1'b1;
                    state_d = S_DECODE;
                end else if (timeout) begin
                    state_d = S_TRAP;
                end else if (wait_q != '1) begin
                    wait_d = wait_q + 1'b1;
                end
            end
            S_DECODE: state_d = S_EXEC;
            S_EXEC: begin
                if (mem_to_reg || mem_write) begin
                    state_d = S_MEM;
                end else if (reg_write) begin
                    state_d = S_WB;
                end else begin
                    pc_we   = 1'b1;
                    state_d = end_state;
                end
            end
            S_MEM: begin
                dmem_req = 1'b1;
                dmem_we  = mem_write;
                if (dmem_ready) begin
                    if (mem_write) begin
                        pc_we   = 1'b1;
                        state_d = end_state;
                    end else begin
                        state_d = S_WB;
                    end
                end else if (timeout) begin
                    state_d = S_TRAP;
                end else if (wait_q != '1) begin
                    wait_d = wait_q + 1'b1;
                end
            end
            S_WB: begin
                rf_we   = reg_write;
                pc_we   = 1'b1;
                state_d = end_state;
            end
            S_TRAP:  state_d = S_TRAP;
            default: state_d = S_IDLE;
        endcase
        // Every fresh request starts its wait budget from zero.
        if ((state_d == S_FETCH || state_d == S_MEM) && state_d != state_q) wait_d = '0;
    end

    always_comb begin
        pc_sel = 2'b00;
        if (pc_we) begin
            if (b_jalr)                pc_sel = 2'b11;
            else if (b_jal)            pc_sel = 2'b10;
            else if (b_beq && alu_zero) pc_sel = 2'b01;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            wait_q  <= '0;
            fault_q <= 1'b0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
            if (state_d == S_TRAP) fault_q <= 1'b1;
        end
    end

    assign state      = state_q;
    assign fault      = fault_q;
    assign instr_done = pc_we;

`ifdef STAGE_SEQUENCER_PERF_CNT_EN
    logic [31:0] retired_q, cycle_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            retired_q <= '0;
            cycle_q   <= '0;
        end else begin
            if (pc_we) retired_q <= retired_q + 32'd1;
            if (state_q != S_IDLE && state_q != S_TRAP) cycle_q <= cycle_q + 32'd1;
        end
    end

    assign retired_cnt = retired_q;
    assign cycle_cnt   = cycle_q;
`else
    assign retired_cnt = '0;
    assign cycle_cnt   = '0;
`endif

endmodule
